regfile_writeback: RTL and testbench

- Write-side controller for the 16x16 register file. It merges two result producers onto the file's single write port:
  - ALU: single-cycle, cannot be stalled.
  - Load unit: valid/ready, can be stalled.
- Load results are buffered in a small FIFO. The block exports a pending-register mask and a forwarding lookup so decode can stall or bypass.
- Drives WriteReg/WriteData/RegWrite of the register file, which captures on the falling clock edge.

---
 rtl/regfile_writeback_pkg.sv | 21 ++
 rtl/regfile_writeback_wb_load_fifo.sv | 109 ++++++++++
 rtl/regfile_writeback.sv | 101 ++++++++++
 tb/tb_regfile_writeback.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared types and helpers for the register-file write-back controller.
package regfile_writeback_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;
    localparam int WB_DEPTH  = 4;
    localparam int WB_NREG   = 2 ** WB_ADDR_W;

    // One queued load result; live drops when a younger ALU write hits the same rd.
    typedef struct packed {
        logic                 live;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot decode of a register index, used to build the pending mask.
    function automatic logic [WB_NREG-1:0] onehot_rd(input logic [WB_ADDR_W-1:0] rd);
        onehot_rd = WB_NREG'(1) << rd;
    endfunction

endpackage

// File: rtl/regfile_writeback_wb_load_fifo.sv
// Load-result FIFO with per-entry live bits, kill-by-rd, pending mask and
// newest-match forwarding lookup.
module regfile_writeback_wb_load_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [ADDR_W-1:0]     push_rd_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic                  pop_i,
    input  logic                  kill_en_i,
    input  logic [ADDR_W-1:0]     kill_rd_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  head_live_o,
    output logic [ADDR_W-1:0]     head_rd_o,
    output logic [DATA_W-1:0]     head_data_o,
    output logic [2**ADDR_W-1:0]  pending_mask_o,
    input  logic [ADDR_W-1:0]     q_reg_i,
    output logic                  q_hit_o,
    output logic [DATA_W-1:0]     q_data_o
);

    localparam int PW = $clog2(DEPTH);

    logic              live_q [DEPTH];
    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [PW:0]       count_q;
    logic [DEPTH-1:0]  occ;
    logic [PW-1:0]     idx;

    // A slot is occupied when its distance from head is below the count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
            assign occ[gi] = ({1'b0, PW'(gi) - head_q} < count_q);
        end
    endgenerate

    assign full_o      = (count_q == (PW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_live_o = live_q[head_q];
    assign head_rd_o   = rd_q[head_q];
    assign head_data_o = data_q[head_q];

    // Entry storage: enqueue at tail (killed on arrival if the ALU targets the same rd), else kill matches.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) live_q[i] <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_i && tail_q == PW'(i)) begin
                    live_q[i] <= !(kill_en_i && kill_rd_i == push_rd_i);
                    rd_q[i]   <= push_rd_i;
                    data_q[i] <= push_data_i;
                end else if (kill_en_i && occ[i] && rd_q[i] == kill_rd_i) begin
                    live_q[i] <= 1'b0;
                end
            end
        end
    end

    // Head/tail pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Pending mask: OR of one-hot rd over occupied live entries.
    always_comb begin
        pending_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && live_q[i]) pending_mask_o = pending_mask_o | onehot_rd(rd_q[i]);
        end
    end

    // Forwarding lookup: walk oldest to newest so the newest match wins.
    always_comb begin
        q_hit_o  = 1'b0;
        q_data_o = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (occ[idx] && live_q[idx] && rd_q[idx] == q_reg_i) begin
                q_hit_o  = 1'b1;
                q_data_o = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: ALU results win, buffered loads drain when
// the ALU is idle, and the write-back stage is registered.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [ADDR_W-1:0]     alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_W-1:0]     ld_rd,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  wb_we,
    output logic [ADDR_W-1:0]     wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic [2**ADDR_W-1:0]  pending_mask,
    input  logic [ADDR_W-1:0]     q_reg,
    output logic                  q_hit,
    output logic [DATA_W-1:0]     q_data
);

    logic              fifo_full;
    logic              fifo_empty;
    logic              head_live;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              pop;
    logic              wb_we_q,   wb_we_d;
    logic [ADDR_W-1:0] wb_rd_q,   wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    // Ready reflects current occupancy only; a same-cycle pop is not credited.
    assign ld_ready = !fifo_full;
    assign push     = ld_valid && ld_ready;
    assign pop      = !alu_valid && !fifo_empty;

    regfile_writeback_wb_load_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_i         (push),
        .push_rd_i      (ld_rd),
        .push_data_i    (ld_data),
        .pop_i          (pop),
        .kill_en_i      (alu_valid),
        .kill_rd_i      (alu_rd),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .head_live_o    (head_live),
        .head_rd_o      (head_rd),
        .head_data_o    (head_data),
        .pending_mask_o (pending_mask),
        .q_reg_i        (q_reg),
        .q_hit_o        (q_hit),
        .q_data_o       (q_data)
    );

    // Source select: ALU first, then FIFO head (dead heads drain with we=0), else hold rd/data.
    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (alu_valid) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = alu_rd;
            wb_data_d = alu_data;
        end else if (!fifo_empty) begin
            wb_we_d   = head_live;
            wb_rd_d   = head_rd;
            wb_data_d = head_data;
        end
    end

    // Write-back register feeding the register file's falling-edge write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a queue-based reference model
// predicts writes and lookup outputs; a monitor checks every write.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_rd = '0;
    logic [15:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [3:0]  ld_rd = '0;
    logic [15:0] ld_data = '0;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] pending_mask;
    logic [3:0]  q_reg = '0;
    logic        q_hit;
    logic [15:0] q_data;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    wb_entry_t   mq[$];      // reference model of queued loads, oldest first
    wb_entry_t   exp_q[$];   // expected register-file writes, in order
    logic [15:0] model_rf [16];
    logic [15:0] tb_rf    [16];

    regfile_writeback #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .pending_mask (pending_mask),
        .q_reg        (q_reg),
        .q_hit        (q_hit),
        .q_data       (q_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; checks combinational outputs against the
    // model state, then advances the model.
    task automatic cycle(input logic rst, input logic av, input logic [3:0] ard,
                         input logic [15:0] adat, input logic lv, input logic [3:0] lrd,
                         input logic [15:0] ldat, input logic [3:0] qr);
        logic [15:0] exp_mask;
        logic        exp_hit;
        logic [15:0] exp_qd;
        logic        acc;
        wb_entry_t   e;
        @(negedge clk);
        reset = rst; alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat; q_reg = qr;
        #2;
        if (!rst) begin
            exp_mask = '0; exp_hit = 1'b0; exp_qd = '0;
            foreach (mq[i]) begin
                if (mq[i].live) begin
                    exp_mask[mq[i].rd] = 1'b1;
                    if (mq[i].rd == qr) begin exp_hit = 1'b1; exp_qd = mq[i].data; end
                end
            end
            check("ld_ready", 32'(ld_ready), 32'(mq.size() < DEPTH));
            check("pending_mask", 32'(pending_mask), 32'(exp_mask));
            check("q_hit", 32'(q_hit), 32'(exp_hit));
            check("q_data", 32'(q_data), 32'(exp_qd));
        end
        if (rst) begin
            mq.delete();
        end else begin
            acc = lv && (mq.size() < DEPTH);
            if (av) begin
                exp_q.push_back('{live: 1'b1, rd: ard, data: adat});
                model_rf[ard] = adat;
                if (acc) mq.push_back('{live: 1'b1, rd: lrd, data: ldat});
                foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
            end else begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    if (e.live) begin
                        exp_q.push_back(e);
                        model_rf[e.rd] = e.data;
                    end
                end
                if (acc) mq.push_back('{live: 1'b1, rd: lrd, data: ldat});
            end
        end
    endtask

    task automatic idle(input int n, input logic [3:0] qr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, qr);
    endtask

    // Called right after a reset cycle: reset still asserted for one more edge.
    task automatic zero_check();
        @(negedge clk);
        #1;
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_pending", 32'(pending_mask), 32'd0);
        check("rst_q_hit", 32'(q_hit), 32'd0);
    endtask

    // Monitor: every write the DUT presents must match the next expected one.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wb_we === 1'b1) begin
                    tb_rf[wb_rd] = wb_data;
                    $display("wb write rd=%0d data=%h", wb_rd, wb_data);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {12'd0, wb_rd, wb_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_rd", 32'(wb_rd), 32'(e.rd));
                        check("wb_data", 32'(wb_data), 32'(e.data));
                    end
                end else if (wb_we !== 1'b0) begin
                    check("wb_we_known", 32'(wb_we), 32'd0);
                end
            end
        end
    end

    initial begin
        for (int r = 0; r < 16; r++) begin model_rf[r] = '0; tb_rf[r] = '0; end

        // Reset then idle
        cycle(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd0);
        cycle(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd0);
        mon_en = 1'b1;
        zero_check();
        idle(2, 4'd0);

        // ALU only
        cycle(1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'd0, 4'd5);
        idle(2, 4'd5);

        // Load only into empty FIFO, lookup on rd 3
        cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'hBEEF, 4'd3);
        idle(3, 4'd3);

        // Back-pressure: ALU busy 6 cycles while 5 loads are offered
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b1, 4'(i + 1), 16'(16'h0100 + i), i < 5, 4'(8 + i), 16'(16'hC000 + i), 4'(8 + i));
        idle(6, 4'd9);

        // Kill rule, load then ALU on a later cycle
        cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h1111, 4'd7);
        cycle(1'b0, 1'b1, 4'd7, 16'h2222, 1'b0, 4'd0, 16'd0, 4'd7);
        idle(3, 4'd7);
        // Kill rule, load and ALU in the same cycle
        cycle(1'b0, 1'b1, 4'd7, 16'h2222, 1'b1, 4'd7, 16'h1111, 4'd7);
        idle(3, 4'd7);

        // Forward priority: two loads to rd 2 held behind ALU traffic
        cycle(1'b0, 1'b1, 4'd0, 16'h0000, 1'b1, 4'd2, 16'hAAAA, 4'd2);
        cycle(1'b0, 1'b1, 4'd0, 16'h0000, 1'b1, 4'd2, 16'hBBBB, 4'd2);
        idle(4, 4'd2);

        // Mid-stream reset with 3 loads queued
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 4'd14, 16'(16'h0E00 + i), 1'b1, 4'(4 + i), 16'(16'hD000 + i), 4'd4);
        cycle(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd4);
        zero_check();
        idle(4, 4'd4);

        // Randomized traffic over a narrow register range so kills are common
        for (int n = 0; n < 400; n++)
            cycle(1'b0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 5)), 16'($urandom),
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 5)), 16'($urandom),
                  4'($urandom_range(0, 5)));

        idle(DEPTH + 3, 4'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        for (int r = 0; r < 16; r++) check($sformatf("regfile[%0d]", r), 32'(tb_rf[r]), 32'(model_rf[r]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
